// File: rtl/ray_dir_recip_pipe_pkg.sv
// Shared formats, latency helpers and lane typedefs for the ray-direction reciprocal pipeline.
package ray_dir_recip_pipe_pkg;

    localparam int RECIP_LANES    = 3;
    localparam int RECIP_IN_W     = 32;
    localparam int RECIP_IN_FRAC  = 16;
    localparam int RECIP_OUT_W    = 36;
    localparam int RECIP_OUT_FRAC = 18;
    localparam int RECIP_BPS      = 1;

    typedef logic signed [RECIP_IN_W-1:0]  recip_in_t;
    typedef logic signed [RECIP_OUT_W-1:0] recip_out_t;
    typedef recip_in_t  [RECIP_LANES-1:0]  recip_in_vec_t;
    typedef recip_out_t [RECIP_LANES-1:0]  recip_out_vec_t;

    function automatic int recip_ndiv(input int qb, input int bps);
        return (qb + bps - 1) / bps;
    endfunction

    // Stage 0 (abs), NDIV divider stages, one saturate/sign stage.
    function automatic int recip_lat(input int qb, input int bps);
        return recip_ndiv(qb, bps) + 2;
    endfunction

endpackage

// File: rtl/ray_dir_recip_pipe_recip_lane.sv
// One lane of the reciprocal pipeline: abs, restoring divide of 2^(IN_FRAC+OUT_FRAC), saturate, sign.
module ray_dir_recip_pipe_recip_lane
    import ray_dir_recip_pipe_pkg::*;
#(
    parameter int IN_W           = RECIP_IN_W,
    parameter int IN_FRAC        = RECIP_IN_FRAC,
    parameter int OUT_W          = RECIP_OUT_W,
    parameter int OUT_FRAC       = RECIP_OUT_FRAC,
    parameter int BITS_PER_STAGE = RECIP_BPS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] inv_o,
    output logic             dbz_o,
    output logic             ovf_o
);

    localparam int QB   = OUT_W - 1;
    localparam int BPS  = BITS_PER_STAGE;
    localparam int NDIV = recip_ndiv(QB, BPS);
    localparam int QP   = NDIV * BPS;
    localparam int K    = IN_FRAC + OUT_FRAC;
    localparam int RW   = IN_W + 1;

    // Dividend bits above the QP resolved quotient bits seed the remainder.
    localparam int R0_SH  = (K >= QP) ? (K - QP) : 0;
    localparam logic [RW-1:0] REM0 = (K >= QP && R0_SH < RW) ? (RW'(1) << R0_SH) : '0;

    // Quotient needs more than QB bits exactly when 2^(K-QB) >= |d|.
    localparam bit THR_ON = (K >= QB);
    localparam int THR_SH = (K >= QB) ? (((K - QB) > IN_W) ? IN_W : (K - QB)) : 0;
    localparam logic [RW-1:0] THR = RW'(1) << THR_SH;

    localparam logic [OUT_W-1:0] MAXV = {1'b0, {QB{1'b1}}};
    localparam logic [QP-1:0]    QMAX = QP'({QB{1'b1}});

    logic [IN_W-1:0] mag_d [NDIV+1];
    logic [IN_W-1:0] mag_q [NDIV+1];
    logic [RW-1:0]   rem_d [NDIV+1];
    logic [RW-1:0]   rem_q [NDIV+1];
    logic [QP-1:0]   quo_d [NDIV+1];
    logic [QP-1:0]   quo_q [NDIV+1];
    logic            neg_d [NDIV+1];
    logic            neg_q [NDIV+1];
    logic            zro_d [NDIV+1];
    logic            zro_q [NDIV+1];
    logic            big_d [NDIV+1];
    logic            big_q [NDIV+1];

    always_comb begin
        logic [IN_W-1:0] mag;
        logic [RW-1:0]   r;
        logic [QP-1:0]   q;
        int              p;
        mag = d_i[IN_W-1] ? -d_i : d_i;
        r   = '0;
        q   = '0;
        p   = 0;

        mag_d[0] = mag;
        rem_d[0] = REM0;
        quo_d[0] = '0;
        neg_d[0] = d_i[IN_W-1];
        zro_d[0] = (d_i == '0);
        big_d[0] = (d_i != '0) && THR_ON && ({1'b0, mag} <= THR);

        for (int s = 0; s < NDIV; s++) begin
            r = rem_q[s];
            q = quo_q[s];
            for (int j = 0; j < BPS; j++) begin
                p = QP - 1 - (s * BPS + j);
                r = {r[RW-2:0], (p == K)};
                q = q << 1;
                if (r >= {1'b0, mag_q[s]}) begin
                    r    = r - {1'b0, mag_q[s]};
                    q[0] = 1'b1;
                end
            end
            mag_d[s+1] = mag_q[s];
            rem_d[s+1] = r;
            quo_d[s+1] = q;
            neg_d[s+1] = neg_q[s];
            zro_d[s+1] = zro_q[s];
            big_d[s+1] = big_q[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv_i) begin
            for (int s = 0; s <= NDIV; s++) begin
                mag_q[s] <= mag_d[s];
                rem_q[s] <= rem_d[s];
                quo_q[s] <= quo_d[s];
                neg_q[s] <= neg_d[s];
                zro_q[s] <= zro_d[s];
                big_q[s] <= big_d[s];
            end
        end
    end

    logic [OUT_W-1:0] inv_d, inv_q;
    logic             dbz_d, dbz_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        logic             sat;
        logic             ovr;
        logic [OUT_W-1:0] val;
        ovr   = !zro_q[NDIV] && (big_q[NDIV] || (quo_q[NDIV] > QMAX));
        sat   = zro_q[NDIV] || ovr;
        val   = sat ? MAXV : OUT_W'(quo_q[NDIV]);
        inv_d = (neg_q[NDIV] && !zro_q[NDIV]) ? -val : val;
        dbz_d = zro_q[NDIV];
        ovf_d = ovr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (adv_i) begin
            inv_q <= inv_d;
            dbz_q <= dbz_d;
            ovf_q <= ovf_d;
        end
    end

    assign inv_o = inv_q;
    assign dbz_o = dbz_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/ray_dir_recip_pipe.sv
// Lock-step multi-lane reciprocal pipeline with valid/ready back-pressure; lanes share one enable.
module ray_dir_recip_pipe
    import ray_dir_recip_pipe_pkg::*;
#(
    parameter int LANES          = RECIP_LANES,
    parameter int IN_W           = RECIP_IN_W,
    parameter int IN_FRAC        = RECIP_IN_FRAC,
    parameter int OUT_W          = RECIP_OUT_W,
    parameter int OUT_FRAC       = RECIP_OUT_FRAC,
    parameter int BITS_PER_STAGE = RECIP_BPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_dir,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_inv,
    output logic [LANES-1:0]       div_by_zero,
    output logic [LANES-1:0]       overflow
);

    localparam int LAT = recip_lat(OUT_W - 1, BITS_PER_STAGE);

    logic [LAT-1:0] vld_d, vld_q;
    logic           adv;

    always_comb begin
        adv   = !vld_q[LAT-1] || out_ready;
        vld_d = vld_q;
        if (adv) begin
            vld_d = {vld_q[LAT-2:0], in_valid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAT-1];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ray_dir_recip_pipe_recip_lane #(
            .IN_W           (IN_W),
            .IN_FRAC        (IN_FRAC),
            .OUT_W          (OUT_W),
            .OUT_FRAC       (OUT_FRAC),
            .BITS_PER_STAGE (BITS_PER_STAGE)
        ) u_lane (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .adv_i  (adv),
            .d_i    (in_dir[l*IN_W +: IN_W]),
            .inv_o  (out_inv[l*OUT_W +: OUT_W]),
            .dbz_o  (div_by_zero[l]),
            .ovf_o  (overflow[l])
        );
    end

endmodule

// File: tb/tb_ray_dir_recip_pipe.sv
// Scoreboard bench for ray_dir_recip_pipe: default instance plus a narrow OUT_W=20 instance.
module tb_ray_dir_recip_pipe;
    import ray_dir_recip_pipe_pkg::*;

    localparam int L    = 3;
    localparam int IW   = 32;
    localparam int OW0  = 36;
    localparam int OW1  = 20;
    localparam int KEXP = RECIP_IN_FRAC + RECIP_OUT_FRAC;
    localparam int LAT0 = OW0 + 1;
    localparam int LAT1 = OW1 + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [L*IW-1:0]   in_dir = '0;
    logic              ir0, ov0, ir1, ov1;
    logic [L*OW0-1:0]  inv0;
    logic [L*OW1-1:0]  inv1;
    logic [L-1:0]      dbz0, ovf0, dbz1, ovf1;

    always #5 clk = ~clk;

    ray_dir_recip_pipe u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_dir(in_dir),
        .out_valid(ov0), .out_ready(out_ready), .out_inv(inv0), .div_by_zero(dbz0),
        .overflow(ovf0)
    );

    ray_dir_recip_pipe #(.OUT_W(OW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_dir(in_dir),
        .out_valid(ov1), .out_ready(out_ready), .out_inv(inv1), .div_by_zero(dbz1),
        .overflow(ovf1)
    );

    typedef struct {
        logic [2:0][63:0] inv;
        logic [2:0]       dbz;
        logic [2:0]       ovf;
        int               acc;
        bit               lc;
    } exp_t;

    exp_t   sb0[$];
    exp_t   sb1[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     lat_chk = 1'b0;
    bit     stall_p [2];
    longint pv [2][3];
    logic [2:0] pd [2];
    logic [2:0] po [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reciprocal from the arithmetic definition: 2^K / |d| truncated, clamped, signed.
    function automatic exp_t model(input logic [L*IW-1:0] dir, input int ow);
        exp_t   e;
        longint d, m, q, mx;
        mx = (longint'(1) << (ow - 1)) - 1;
        for (int i = 0; i < L; i++) begin
            d = longint'($signed(dir[i*IW +: IW]));
            e.dbz[i] = 1'b0;
            e.ovf[i] = 1'b0;
            if (d == 0) begin
                e.inv[i] = mx;
                e.dbz[i] = 1'b1;
            end else begin
                m = (d < 0) ? -d : d;
                q = (longint'(1) << KEXP) / m;
                if (q > mx) begin
                    q = mx;
                    e.ovf[i] = 1'b1;
                end
                e.inv[i] = (d < 0) ? -q : q;
            end
        end
        e.acc = cyc;
        e.lc  = lat_chk;
        return e;
    endfunction

    task automatic mon(input int u, input logic ov, input logic ir, input longint g0,
                       input longint g1, input longint g2, input logic [2:0] d,
                       input logic [2:0] o);
        longint g [3];
        exp_t   e;
        int     n;
        g[0] = g0; g[1] = g1; g[2] = g2;
        if (stall_p[u]) begin
            chk($sformatf("dut%0d_stall_valid", u), longint'(ov), 1);
            for (int i = 0; i < 3; i++) chk($sformatf("dut%0d_stall_inv%0d", u, i), g[i], pv[u][i]);
            chk($sformatf("dut%0d_stall_flags", u), longint'({d, o}), longint'({pd[u], po[u]}));
        end
        if (ov && !out_ready) begin
            chk($sformatf("dut%0d_stall_in_ready", u), longint'(ir), 0);
            stall_p[u] = 1'b1;
            for (int i = 0; i < 3; i++) pv[u][i] = g[i];
            pd[u] = d;
            po[u] = o;
        end else begin
            stall_p[u] = 1'b0;
        end
        if (ov && out_ready) begin
            n = (u == 0) ? sb0.size() : sb1.size();
            if (n == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut%0d_unexpected_output: out_valid=1, expected no result", u);
            end else begin
                e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
                for (int i = 0; i < 3; i++) chk($sformatf("dut%0d_inv_lane%0d", u, i), g[i], e.inv[i]);
                chk($sformatf("dut%0d_div_by_zero", u), longint'(d), longint'(e.dbz));
                chk($sformatf("dut%0d_overflow", u), longint'(o), longint'(e.ovf));
                if (e.lc) chk($sformatf("dut%0d_latency", u), cyc - e.acc, (u == 0) ? LAT0 : LAT1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ov0, ir0, longint'($signed(inv0[0*OW0 +: OW0])),
                longint'($signed(inv0[1*OW0 +: OW0])), longint'($signed(inv0[2*OW0 +: OW0])),
                dbz0, ovf0);
            mon(1, ov1, ir1, longint'($signed(inv1[0*OW1 +: OW1])),
                longint'($signed(inv1[1*OW1 +: OW1])), longint'($signed(inv1[2*OW1 +: OW1])),
                dbz1, ovf1);
        end
    end

    task automatic drive(input bit v, input logic [L*IW-1:0] dir, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_dir    = dir;
        out_ready = ordy;
        @(negedge clk);
        acc = v && ir0;
        if (v && ir0) sb0.push_back(model(dir, OW0));
        if (v && ir1) sb1.push_back(model(dir, OW1));
    endtask

    function automatic logic [IW-1:0] rand_lane();
        logic [IW-1:0] x;
        case ($urandom_range(0, 6))
            0:       x = '0;
            1:       x = 32'h8000_0000;
            2:       x = $urandom_range(1, 4);
            3:       x = $urandom_range(1, 65536);
            4:       x = $urandom;
            default: x = $urandom_range(1 << 14, 1 << 24);
        endcase
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    function automatic logic [L*IW-1:0] rand_vec();
        return {rand_lane(), rand_lane(), rand_lane()};
    endfunction

    task automatic drain();
        bit a;
        for (int i = 0; i < 100 && (sb0.size() != 0 || sb1.size() != 0); i++) drive(1'b0, '0, 1'b1, a);
        n_chk++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: outstanding %0d/%0d, expected 0/0", sb0.size(), sb1.size());
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out_valid0"}, longint'(ov0), 0);
        chk({nm, "_out_valid1"}, longint'(ov1), 0);
        chk({nm, "_out_inv0"}, longint'(inv0 != '0), 0);
        chk({nm, "_out_inv1"}, longint'(inv1 != '0), 0);
        chk({nm, "_flags"}, longint'({dbz0, ovf0, dbz1, ovf1}), 0);
    endtask

    initial begin
        bit a;
        stall_p[0] = 1'b0;
        stall_p[1] = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        chk("reset_in_ready", longint'(ir0), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, first accept after reset, latency checked.
        lat_chk = 1'b1;
        drive(1'b1, {32'd0, 32'd2048, 32'd8192}, 1'b1, a);
        drive(1'b1, {32'h8000_0000, 32'd1, 32'hFFFF_0000}, 1'b1, a);
        drive(1'b1, {32'd0, 32'hFFFF_FFFF, 32'd1}, 1'b1, a);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_vec(), 1'b1, a);
            chk("b2b_accept", longint'(a), 1);
        end
        lat_chk = 1'b0;
        drain();

        // Random traffic with random back-pressure and one forced 5-cycle stall.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_vec(),
                  (i >= 200 && i < 205) ? 1'b0 : ($urandom_range(0, 9) < 7), a);
        end
        drain();

        // Reset with vectors in flight.
        for (int i = 0; i < 20; i++) drive(1'b1, rand_vec(), 1'b1, a);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb0.delete();
        sb1.delete();
        stall_p[0] = 1'b0;
        stall_p[1] = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (45) drive(1'b0, '0, 1'b1, a);
        lat_chk = 1'b1;
        drive(1'b1, {32'd7, 32'hFFFF_FFFF, 32'd1}, 1'b1, a);
        lat_chk = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
